native_port_arbiter: RTL

- Shares one Valid-Ready Native memory port between two cache-to-native bridges, e.g. the I-side and D-side L1 bridges.
- Arbitrates requests round-robin, locks the grant until the handshake completes, and records the issuer of every read in an in-order tag FIFO.
- Routes each returning update to the requester that issued the read.
- Sits between the bridges and the memory/interconnect port.

---
 rtl/native_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/native_port_arbiter.sv
// native_port_arbiter: shares one valid/ready native memory port between
// two requesters, with round-robin grant, grant lock and in-order read tags.
module native_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s0_request_valid,
    output logic                                 s0_request_ready,
    input  logic [1:0]                           s0_request_op,
    input  logic [ADDR_WIDTH-1:0]                s0_request_addr,
    input  logic [DATA_WIDTH-1:0]                s0_request_data,
    output logic                                 s0_update_valid,
    input  logic                                 s0_update_ready,
    output logic [DATA_WIDTH-1:0]                s0_update_data,
    input  logic                                 s1_request_valid,
    output logic                                 s1_request_ready,
    input  logic [1:0]                           s1_request_op,
    input  logic [ADDR_WIDTH-1:0]                s1_request_addr,
    input  logic [DATA_WIDTH-1:0]                s1_request_data,
    output logic                                 s1_update_valid,
    input  logic                                 s1_update_ready,
    output logic [DATA_WIDTH-1:0]                s1_update_data,
    output logic                                 m_request_valid,
    input  logic                                 m_request_ready,
    output logic [1:0]                           m_request_op,
    output logic [ADDR_WIDTH-1:0]                m_request_addr,
    output logic [DATA_WIDTH-1:0]                m_request_data,
    input  logic                                 m_update_valid,
    output logic                                 m_update_ready,
    input  logic [DATA_WIDTH-1:0]                m_update_data,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_WR = 2'b10;

    logic                       ptr;
    logic                       lock;
    logic                       grant_id;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic                       err_q;

    logic                       full;
    logic                       elig0;
    logic                       elig1;
    logic                       gnt;
    logic                       active;
    logic [1:0]                 g_op;
    logic                       illegal;
    logic                       fire;
    logic                       issue_rd;
    logic                       tag_valid;
    logic                       tag;
    logic                       pop;
    logic                       spurious;

    // A read is eligible only while a tag slot is free in the registered count.
    always_comb begin
        full  = (count == CW'(MAX_OUTSTANDING));
        elig0 = s0_request_valid && !((s0_request_op == OP_RD) && full);
        elig1 = s1_request_valid && !((s1_request_op == OP_RD) && full);
    end

    // Grant selection and zero-cycle forwarding of the winning request.
    always_comb begin
        if (lock)
            gnt = grant_id;
        else if (elig0 && elig1)
            gnt = ptr;
        else
            gnt = elig1;
        active          = !rst && (gnt ? elig1 : elig0);
        g_op            = gnt ? s1_request_op : s0_request_op;
        illegal         = (g_op != OP_RD) && (g_op != OP_WR);
        m_request_valid = active && !illegal;
        m_request_op    = m_request_valid ? g_op : 2'b00;
        m_request_addr  = gnt ? s1_request_addr : s0_request_addr;
        m_request_data  = gnt ? s1_request_data : s0_request_data;
        fire            = active && (illegal || m_request_ready);
        s0_request_ready = fire && !gnt;
        s1_request_ready = fire && gnt;
        issue_rd        = m_request_valid && m_request_ready
                          && (g_op == OP_RD);
    end

    // Return path: the oldest tag decides which requester sees the update.
    always_comb begin
        tag_valid       = (count != '0);
        tag             = tag_mem[rd_ptr];
        s0_update_valid = !rst && m_update_valid && tag_valid && !tag;
        s1_update_valid = !rst && m_update_valid && tag_valid && tag;
        m_update_ready  = !rst && tag_valid
                          && (tag ? s1_update_ready : s0_update_ready);
        s0_update_data  = m_update_data;
        s1_update_data  = m_update_data;
        pop             = m_update_valid && m_update_ready;
        spurious        = !rst && m_update_valid && !tag_valid;
        outstanding     = count;
        err             = err_q;
    end

    // Pointer, lock, tag FIFO, in-flight count and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= 1'b0;
            lock     <= 1'b0;
            grant_id <= 1'b0;
            tag_mem  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (fire) begin
                ptr  <= ~gnt;
                lock <= 1'b0;
            end else if (m_request_valid && !m_request_ready) begin
                lock     <= 1'b1;
                grant_id <= gnt;
            end
            if (issue_rd) begin
                tag_mem[wr_ptr] <= gnt;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (issue_rd && !pop)
                count <= count + CW'(1);
            else if (!issue_rd && pop)
                count <= count - CW'(1);
            if ((fire && illegal) || spurious)
                err_q <= 1'b1;
        end
    end

endmodule
